// File: rtl/sopc_led_pwm_pio_if.sv
// ---------------------------------------------------------------------------
// sopc_led_pwm_pio_if
// Avalon-MM slave bus bundle for the LED PWM PIO.
//   address     4-bit word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit read data (driven by the slave)
// Modports: master (CPU side), slave (PIO side).
// ---------------------------------------------------------------------------
interface sopc_led_pwm_pio_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sopc_led_pwm_pio.sv
// ---------------------------------------------------------------------------
// sopc_led_pwm_pio
// Zero-wait-state Avalon-MM output PIO for board LEDs with atomic SET/CLEAR
// writes and per-channel PWM dimming. Duty changes are double-buffered: a
// written duty only becomes active at the start of a PWM period, so a
// channel never shows a truncated or stretched pulse.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   avs       Avalon-MM slave bus (sopc_led_pwm_pio_if.slave)
//   out_port  registered LED drive, NUM_CH bits
// Register map (word address):
//   0 DATA  1 SET  2 CLEAR  3 PWM_EN  4 PRESCALE  5 COUNT  8+i DUTY[i]
// ---------------------------------------------------------------------------
module sopc_led_pwm_pio #(
  parameter int NUM_CH = 2,
  parameter int DUTY_W = 8,
  parameter int PRE_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sopc_led_pwm_pio_if.slave    avs,
  output logic [NUM_CH-1:0]    out_port
);

  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  // Register state
  logic [NUM_CH-1:0] data_q,     data_d;
  logic [NUM_CH-1:0] pwm_en_q,   pwm_en_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [PRE_W-1:0]  pre_cnt_q,  pre_cnt_d;
  logic [DUTY_W-1:0] pwm_cnt_q,  pwm_cnt_d;
  logic [DUTY_W-1:0] duty_q [NUM_CH];
  logic [DUTY_W-1:0] duty_d [NUM_CH];
  logic [DUTY_W-1:0] act_q  [NUM_CH];
  logic [DUTY_W-1:0] act_d  [NUM_CH];
  logic [NUM_CH-1:0] out_q;

  // Combinational helpers
  logic              wr_s;
  logic              tick_s;
  logic              period_start_s;
  logic [NUM_CH-1:0] lvl_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  // Upper writedata bits are deliberately ignored for narrow fields.
  assign unused_s = ^avs.writedata;

  // Next-state logic: bus writes, prescaler, PWM counter, duty shadow, levels
  always_comb begin
    wr_s           = avs.chipselect && !avs.write_n;
    tick_s         = (pre_cnt_q == prescale_q);
    period_start_s = tick_s && (pwm_cnt_q == CNT_MAX);

    data_d     = data_q;
    pwm_en_d   = pwm_en_q;
    prescale_d = prescale_q;

    if (wr_s) begin
      case (avs.address)
        4'd0:    data_d     = avs.writedata[NUM_CH-1:0];
        4'd1:    data_d     = data_q | avs.writedata[NUM_CH-1:0];
        4'd2:    data_d     = data_q & ~avs.writedata[NUM_CH-1:0];
        4'd3:    pwm_en_d   = avs.writedata[NUM_CH-1:0];
        4'd4:    prescale_d = avs.writedata[PRE_W-1:0];
        default: data_d     = data_q;  // COUNT, DUTY and unmapped handled elsewhere
      endcase
    end else begin
      data_d = data_q;
    end

    // A PRESCALE write restarts the tick spacing from the write edge.
    if (wr_s && (avs.address == 4'd4)) begin
      pre_cnt_d = '0;
    end else if (tick_s) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1'b1);
    end

    // Natural wrap at 2^DUTY_W-1 -> 0.
    if (tick_s) begin
      pwm_cnt_d = pwm_cnt_q + DUTY_W'(1'b1);
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_s && (avs.address == 4'(8 + i))) begin
        duty_d[i] = avs.writedata[DUTY_W-1:0];
      end else begin
        duty_d[i] = duty_q[i];
      end

      // act loads the pre-edge pending value, so a DUTY write landing on
      // the period_start edge only takes effect one period later.
      if (period_start_s) begin
        act_d[i] = duty_q[i];
      end else begin
        act_d[i] = act_q[i];
      end

      if (pwm_en_q[i]) begin
        lvl_s[i] = data_q[i] && (pwm_cnt_q < act_q[i]);
      end else begin
        lvl_s[i] = data_q[i];
      end
    end
  end

  // Read mux: combinational from address, unused bits zero
  always_comb begin
    rdata_s = 32'd0;
    case (avs.address)
      4'd0, 4'd1, 4'd2: rdata_s = 32'(data_q);
      4'd3:             rdata_s = 32'(pwm_en_q);
      4'd4:             rdata_s = 32'(prescale_q);
      4'd5:             rdata_s = 32'(pwm_cnt_q);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (avs.address == 4'(8 + i)) begin
            rdata_s = 32'(duty_q[i]);
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
  end

  assign avs.readdata = rdata_s;
  assign out_port     = out_q;

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      pwm_en_q   <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      out_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      data_q     <= data_d;
      pwm_en_q   <= pwm_en_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      out_q      <= lvl_s;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= duty_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

endmodule
